// File: rtl/led_blink_arbiter.sv
// led_blink_arbiter: round-robin arbiter sharing one status LED between requesters that each ask for a burst of blinks
// Ports: clk, rst (async, active high); req[NUM_REQ] level requests; blink_count[NUM_REQ*CNT_W] per-requester blink counts;
// gnt one-hot grant held for the burst; done one-cycle completion pulse; led drive (1 = on); busy from grant through done.
module led_blink_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int CNT_W        = 8,
  parameter int PRESCALE_DIV = 6000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] blink_count,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic                     led,
  output logic                     busy
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int PW = $clog2(PRESCALE_DIV);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);
  typedef enum logic [1:0] {IDLE, ON, OFF, FIN} state_t;
  state_t            st_q;
  logic [IW-1:0]     rr_q, idx_q, pick_d;
  logic [PW-1:0]     pre_q;
  logic [CNT_W-1:0]  rem_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_q, done_q;
  logic              led_q, busy_q, tick;
  always_comb begin
    pick_d = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      // the lowest offset from rr_q wins, so walk offsets downward
      if (req[(int'(rr_q) + k) % NUM_REQ]) pick_d = IW'((int'(rr_q) + k) % NUM_REQ);
    end
    cnt_d = blink_count[int'(pick_d)*CNT_W +: CNT_W];
  end
  assign tick = pre_q == PW'(PRESCALE_DIV - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= IDLE;
      rr_q   <= '0;
      idx_q  <= '0;
      pre_q  <= '0;
      rem_q  <= '0;
      gnt_q  <= '0;
      done_q <= '0;
      led_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      done_q <= '0;
      case (st_q)
        IDLE: if (|req) begin
          idx_q  <= pick_d;
          rem_q  <= cnt_d;
          pre_q  <= '0;
          gnt_q  <= ONE << pick_d;
          busy_q <= 1'b1;
          led_q  <= cnt_d != '0;
          st_q   <= cnt_d == '0 ? FIN : ON;
        end
        ON: begin
          pre_q <= tick ? '0 : pre_q + 1'b1;
          if (tick) begin
            led_q <= 1'b0;
            st_q  <= OFF;
          end
        end
        OFF: begin
          pre_q <= tick ? '0 : pre_q + 1'b1;
          if (tick && rem_q == CNT_W'(1)) begin
            gnt_q  <= '0;
            done_q <= ONE << idx_q;
            st_q   <= FIN;
          end else if (tick) begin
            rem_q <= rem_q - 1'b1;
            led_q <= 1'b1;
            st_q  <= ON;
          end
        end
        default: begin
          // a zero-count burst enters FIN with gnt still up for its one grant cycle; emit done on the next
          if (|gnt_q) begin
            gnt_q  <= '0;
            done_q <= ONE << idx_q;
          end else begin
            busy_q <= 1'b0;
            rr_q   <= idx_q == IW'(NUM_REQ - 1) ? '0 : idx_q + 1'b1;
            st_q   <= IDLE;
          end
        end
      endcase
    end
  end
  assign gnt  = gnt_q;
  assign done = done_q;
  assign led  = led_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_led_blink_arbiter.sv
// tb_led_blink_arbiter: directed self-checking bench for led_blink_arbiter
module tb_led_blink_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] bc = '0;
  logic [3:0]  gnt, done;
  logic        led, busy;
  int          n_chk = 0;
  int          n_err = 0;
  led_blink_arbiter #(.NUM_REQ(4), .CNT_W(8), .PRESCALE_DIV(4)) dut (
    .clk(clk), .rst(rst), .req(req), .blink_count(bc),
    .gnt(gnt), .done(done), .led(led), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic reset_dut();
    rst = 1'b1;
    req = '0;
    step();
    rst = 1'b0;
  endtask
  task automatic watch(input int c0, input int p0, output int c, output int p, output logic [3:0] d);
    logic prev;
    c = c0;
    p = p0;
    prev = led;
    d = '0;
    while (c < 3000) begin
      step();
      c++;
      if (led && !prev) p++;
      prev = led;
      if (done != '0) begin
        d = done;
        break;
      end
    end
  endtask
  initial begin
    int c, p;
    logic [3:0] d;
    logic [3:0] order [5];
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    step();
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_led", led, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    req = 4'b0001;
    bc = 32'h0000_0002;
    for (int i = 1; i <= 18; i++) begin
      step();
      if (i == 1) req = '0;
      chk($sformatf("t1_led_c%0d", i), led, (i <= 16) ? (((i - 1) / 4) % 2 == 0) : 0);
      chk($sformatf("t1_gnt_c%0d", i), gnt, (i <= 16) ? 1 : 0);
      chk($sformatf("t1_done_c%0d", i), done, (i == 17) ? 1 : 0);
      chk($sformatf("t1_busy_c%0d", i), busy, (i <= 17) ? 1 : 0);
    end
    reset_dut();
    req = 4'b1111;
    bc = 32'h0101_0101;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("t2_gnt_first%0d", k), gnt, order[k]);
      repeat (7) step();
      chk($sformatf("t2_gnt_last%0d", k), gnt, order[k]);
      step();
      if (k == 4) req = '0;
      chk($sformatf("t2_done%0d", k), done, order[k]);
      chk($sformatf("t2_fin_gnt%0d", k), gnt, 0);
      step();
      chk($sformatf("t2_idle_gnt%0d", k), gnt, 0);
      chk($sformatf("t2_idle_busy%0d", k), busy, 0);
    end
    reset_dut();
    req = 4'b0100;
    bc = 32'h0000_0000;
    step();
    req = '0;
    chk("t3_gnt", gnt, 4'b0100);
    chk("t3_led1", led, 0);
    chk("t3_done1", done, 0);
    step();
    chk("t3_done2", done, 4'b0100);
    chk("t3_gnt2", gnt, 0);
    chk("t3_led2", led, 0);
    chk("t3_busy2", busy, 1);
    step();
    chk("t3_done3", done, 0);
    chk("t3_busy3", busy, 0);
    reset_dut();
    req = 4'b0010;
    bc = 32'h0000_0300;
    step();
    chk("t4_gnt", gnt, 4'b0010);
    step();
    req = '0;
    bc = 32'h0000_0900;
    watch(2, 1, c, p, d);
    chk("t4_blinks", p, 3);
    chk("t4_done_cycle", c, 25);
    chk("t4_done", d, 4'b0010);
    step();
    req = 4'b0010;
    bc = 32'h0000_0500;
    step();
    chk("t5_gnt", gnt, 4'b0010);
    repeat (5) step();
    rst = 1'b1;
    #1;
    chk("t5_async_gnt", gnt, 0);
    chk("t5_async_led", led, 0);
    chk("t5_async_busy", busy, 0);
    step();
    chk("t5_no_done", done, 0);
    rst = 1'b0;
    req = 4'b0011;
    step();
    chk("t5_regrant", gnt, 4'b0001);
    reset_dut();
    req = 4'b0001;
    bc = 32'h0000_00ff;
    step();
    req = '0;
    chk("t6_gnt", gnt, 4'b0001);
    watch(1, 1, c, p, d);
    chk("t6_blinks", p, 255);
    chk("t6_done_cycle", c, 2041);
    chk("t6_done", d, 4'b0001);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
